// File: rtl/mole_pkg.sv
// Shared constants and types for the whack-a-mole answer datapath.
// NIBBLES is also the game controller's answer index limit.
package mole_pkg;

  localparam int          NIBBLES      = 8;
  localparam logic [31:0] LFSR_MASK    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2023;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DELIVER
  } state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/mole_lfsr32.sv
// Free-running 32-bit Galois LFSR; a seed load overrides the step and a zero seed
// falls back to DEFAULT_SEED. Exposes the low nibble, which is the pattern candidate.
module mole_lfsr32
  import mole_pkg::*;
#(
  parameter logic [31:0] DEFAULT_SEED = mole_pkg::DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_seed_load,
  input  logic [31:0] i_seed_in,
  output logic [3:0]  o_cand
);

  logic [31:0] r_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= DEFAULT_SEED;
    end else if (i_seed_load) begin
      r_lfsr <= (i_seed_in == 32'h0) ? DEFAULT_SEED : i_seed_in;
    end else begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign o_cand = r_lfsr[3:0];

endmodule

// File: rtl/mole_pattern_gen.sv
// Answer-pattern generator: builds eight distinct-neighbour mole positions from the LFSR
// and hands them to the game controller with a one-cycle write strobe.
module mole_pattern_gen
  import mole_pkg::*;
#(
  parameter int          NUM_HOLES    = 9,
  parameter logic [31:0] DEFAULT_SEED = mole_pkg::DEFAULT_SEED,
  parameter int          MAX_REJECT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_load,
  input  logic [31:0] seed_in,
  input  logic        req,
  input  logic        game_start,
  output logic [31:0] data_out,
  output logic        write_enable,
  output logic        busy,
  output logic [7:0]  pattern_count
);

  localparam int            RW        = $clog2(MAX_REJECT + 1);
  localparam logic [RW-1:0] REJ_LIMIT = RW'(MAX_REJECT - 1);
  localparam logic [4:0]    HOLES     = 5'(NUM_HOLES);
  localparam logic [3:0]    LAST_HOLE = 4'(NUM_HOLES - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(NIBBLES - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [27:0]   r_pat;
  logic [3:0]    r_ref;
  logic [2:0]    r_idx;
  logic [RW-1:0] r_rej;
  logic          r_pending;

  logic       w_req_any;
  logic [3:0] w_cand;
  logic [3:0] w_nib;
  logic       w_ok;
  logic       w_force;
  logic       w_acc;

  mole_lfsr32 #(
    .DEFAULT_SEED(DEFAULT_SEED)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .i_seed_load(seed_load),
    .i_seed_in  (seed_in),
    .o_cand     (w_cand)
  );

  // r_ref is the last accepted nibble; between patterns it is the previous pattern's
  // nibble 7, so nibble 0 automatically avoids it.
  always_comb begin
    w_req_any   = req | game_start;
    w_ok        = ({1'b0, w_cand} < HOLES) && (w_cand != r_ref);
    w_force     = !w_ok && (r_rej == REJ_LIMIT);
    w_acc       = w_ok | w_force;
    w_nib       = w_cand;
    w_state_nxt = r_state;
    if (!w_ok) begin
      w_nib = (r_ref == 4'hF || r_ref == LAST_HOLE) ? 4'h0 : r_ref + 4'h1;
    end
    case (r_state)
      IDLE:    if (w_req_any || r_pending) w_state_nxt = GEN;
      GEN:     if (w_acc && r_idx == LAST_IDX) w_state_nxt = DELIVER;
      DELIVER: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pat         <= '0;
      r_ref         <= 4'hF;
      r_idx         <= '0;
      r_rej         <= '0;
      r_pending     <= 1'b0;
      data_out      <= '0;
      write_enable  <= 1'b0;
      busy          <= 1'b0;
      pattern_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      busy         <= (w_state_nxt != IDLE);
      write_enable <= (w_state_nxt == DELIVER);
      case (r_state)
        IDLE: begin
          r_pending <= 1'b0;
          r_idx     <= '0;
          r_rej     <= '0;
        end
        GEN: begin
          if (w_req_any) r_pending <= 1'b1;
          if (w_acc) begin
            r_pat <= {w_nib, r_pat[27:4]};
            r_ref <= w_nib;
            r_idx <= r_idx + 3'd1;
            r_rej <= '0;
            // Publish on entry to DELIVER so data_out is valid with the strobe.
            if (r_idx == LAST_IDX) begin
              data_out <= {w_nib, r_pat};
              if (pattern_count != 8'hFF) pattern_count <= pattern_count + 8'd1;
            end
          end else begin
            r_rej <= r_rej + RW'(1);
          end
        end
        DELIVER: begin
          if (w_req_any) r_pending <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
